pipeline_trace_buffer: RTL and testbench

//  Synthesizable on-chip trace unit for RISC-V pipeline debug; it replaces the bench-only PC/branch prints.
//  It sits beside the core and samples the fetch PC, the ID-stage instruction and the branch-resolution signals.
//  It records PC discontinuities and conditional branches into a DEPTH-entry circular buffer and keeps saturating event counters.
//  A PC-match trigger stops capture POST_TRIG entries after the match, so the buffer holds the history leading up to the event.

---
 rtl/pipeline_trace_buffer_if.sv | 27 ++
 rtl/pipeline_trace_buffer.sv | 230 +++++++++++++++++++++++
 tb/tb_pipeline_trace_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_trace_buffer_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pipeline_trace_buffer_if : show-ahead read port of the trace buffer
// Rev 1.0
// -----------------------------------------------------------------------------
interface pipeline_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_target;
  logic [2:0]      rd_funct3;
  logic            rd_taken;
  logic            rd_is_branch;

  modport master (
    output rd_valid, rd_pc, rd_target, rd_funct3, rd_taken, rd_is_branch,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_target, rd_funct3, rd_taken, rd_is_branch,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_trace_buffer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pipeline_trace_buffer : PC-discontinuity / branch trace ring with PC trigger
// Rev 1.0
// -----------------------------------------------------------------------------
module pipeline_trace_buffer #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int POST_TRIG  = 4,
  parameter int OVERWRITE  = 1,
  parameter int TRACE_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [XLEN-1:0]          pc,
  input  logic [31:0]              id_instr,
  input  logic                     branch_taken,
  input  logic [XLEN-1:0]          branch_target,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  pipeline_trace_buffer_if.master  rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     frozen,
  output logic [CNT_W-1:0]         cnt_cycles,
  output logic [CNT_W-1:0]         cnt_branches,
  output logic [CNT_W-1:0]         cnt_taken,
  output logic [CNT_W-1:0]         cnt_disc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(POST_TRIG + 2);

  localparam logic [6:0]    c_op_branch = 7'b1100011;
  localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
  localparam logic [PW-1:0] c_post_trig = PW'(POST_TRIG);
  localparam bit            c_overwrite = (OVERWRITE != 0);
  localparam bit            c_rec_disc  = (TRACE_MODE == 0);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [2:0]      funct3;
    logic            taken;
    logic            is_branch;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [XLEN-1:0] r_pc_prev;
  logic            r_first;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;
  logic [CNT_W-1:0] r_cnt_cycles;
  logic [CNT_W-1:0] r_cnt_branches;
  logic [CNT_W-1:0] r_cnt_taken;
  logic [CNT_W-1:0] r_cnt_disc;
  state_t          r_state;
  logic [PW-1:0]   r_post_cnt;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_post_nxt;
  logic            w_is_branch;
  logic            w_disc;
  logic            w_event;
  logic            w_wr_req;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_store;
  logic            w_lost;
  logic            w_adv_rd;
  logic            w_trig;
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_unused_bits;

  assign w_unused_bits = &{id_instr[31:15], id_instr[11:7]};

  // A stall (pc unchanged) and straight-line fetch (pc_prev+4) are not events
  assign w_is_branch = enable && (id_instr[6:0] == c_op_branch);
  assign w_disc      = enable && !r_first && (pc != r_pc_prev) &&
                       (pc != r_pc_prev + XLEN'(4));
  assign w_event     = w_is_branch || (w_disc && c_rec_disc);
  assign w_trig      = enable && trig_en && (pc == trig_pc);

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == c_depth);
  assign w_wr_req = !clear && w_event && (r_state != ST_FROZEN);
  assign w_pop    = !clear && !w_empty && rd.rd_ready;
  assign w_lost   = w_wr_req && w_full && !w_pop;
  assign w_store  = w_wr_req && (!w_full || w_pop || c_overwrite);
  // Overwriting a full ring retires the oldest entry along with the write
  assign w_adv_rd = w_pop || (w_lost && c_overwrite);

  always_comb begin
    w_entry = '0;
    if (w_is_branch) begin
      w_entry.pc        = pc;
      w_entry.target    = branch_target;
      w_entry.funct3    = id_instr[14:12];
      w_entry.taken     = branch_taken;
      w_entry.is_branch = 1'b1;
    end else begin
      w_entry.pc     = r_pc_prev;
      w_entry.target = pc;
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc_prev      <= '0;
      r_first        <= 1'b1;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_overflow     <= 1'b0;
      r_cnt_cycles   <= '0;
      r_cnt_branches <= '0;
      r_cnt_taken    <= '0;
      r_cnt_disc     <= '0;
    end else if (clear) begin
      r_first        <= 1'b1;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_overflow     <= 1'b0;
      r_cnt_cycles   <= '0;
      r_cnt_branches <= '0;
      r_cnt_taken    <= '0;
      r_cnt_disc     <= '0;
    end else begin
      if (enable) begin
        r_pc_prev <= pc;
        r_first   <= 1'b0;
        if (!(&r_cnt_cycles)) r_cnt_cycles <= r_cnt_cycles + CNT_W'(1);
      end
      if (w_is_branch && !(&r_cnt_branches)) r_cnt_branches <= r_cnt_branches + CNT_W'(1);
      if (w_is_branch && branch_taken && !(&r_cnt_taken)) r_cnt_taken <= r_cnt_taken + CNT_W'(1);
      if (w_disc && !(&r_cnt_disc)) r_cnt_disc <= r_cnt_disc + CNT_W'(1);

      if (w_store)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_adv_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_store && !w_adv_rd) begin
        r_level <= r_level + LW'(1);
      end else if (!w_store && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      if (w_lost) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_ARMED;
      r_post_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_nxt;
    end
  end

  // The trigger-cycle entry is written while still ARMED and is not counted
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    if (clear) begin
      w_state_nxt = ST_ARMED;
      w_post_nxt  = '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_trig) begin
            w_post_nxt  = '0;
            w_state_nxt = (c_post_trig == '0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (w_store) begin
            w_post_nxt = r_post_cnt + PW'(1);
            if (r_post_cnt + PW'(1) == c_post_trig) w_state_nxt = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          w_state_nxt = ST_FROZEN;
        end
        default: begin
          w_state_nxt = ST_ARMED;
          w_post_nxt  = '0;
        end
      endcase
    end
  end

  // Head data is forced to zero when empty so reset shows all-zero outputs
  assign w_head          = r_mem[r_rd_ptr];
  assign rd.rd_valid     = !w_empty;
  assign rd.rd_pc        = w_empty ? '0 : w_head.pc;
  assign rd.rd_target    = w_empty ? '0 : w_head.target;
  assign rd.rd_funct3    = w_empty ? '0 : w_head.funct3;
  assign rd.rd_taken     = !w_empty && w_head.taken;
  assign rd.rd_is_branch = !w_empty && w_head.is_branch;

  assign level        = r_level;
  assign overflow     = r_overflow;
  assign frozen       = (r_state == ST_FROZEN);
  assign cnt_cycles   = r_cnt_cycles;
  assign cnt_branches = r_cnt_branches;
  assign cnt_taken    = r_cnt_taken;
  assign cnt_disc     = r_cnt_disc;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_buffer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pipeline_trace_buffer : directed vectors with an entry scoreboard
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_pipeline_trace_buffer;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BGE = {7'd0, 5'd2, 5'd1, 3'b101, 5'd8, 7'b1100011};
  localparam logic [31:0] BEQ = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  funct3;
    logic        taken;
    logic        is_branch;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] id_instr = NOP;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        rd_ready = 1'b0;

  logic [2:0]  level_a, level_b;
  logic        overflow_a, overflow_b, frozen_a, frozen_b;
  logic [31:0] cyc_a, br_a, tk_a, disc_a;
  logic [31:0] cyc_b, br_b, tk_b, disc_b;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t exp_q[$];
  ent_t mon_act, mon_exp;

  pipeline_trace_buffer_if #(.XLEN(XLEN)) rd_a ();
  pipeline_trace_buffer_if #(.XLEN(XLEN)) rd_b ();
  assign rd_a.rd_ready = rd_ready;
  assign rd_b.rd_ready = rd_ready;

  pipeline_trace_buffer #(
    .XLEN(XLEN), .DEPTH(4), .CNT_W(32), .POST_TRIG(2), .OVERWRITE(1), .TRACE_MODE(0)
  ) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .pc(pc),
    .id_instr(id_instr), .branch_taken(branch_taken), .branch_target(branch_target),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd(rd_a), .level(level_a),
    .overflow(overflow_a), .frozen(frozen_a), .cnt_cycles(cyc_a),
    .cnt_branches(br_a), .cnt_taken(tk_a), .cnt_disc(disc_a)
  );

  pipeline_trace_buffer #(
    .XLEN(XLEN), .DEPTH(4), .CNT_W(32), .POST_TRIG(2), .OVERWRITE(0), .TRACE_MODE(0)
  ) u_dut_nov (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .pc(pc),
    .id_instr(id_instr), .branch_taken(branch_taken), .branch_target(branch_target),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd(rd_b), .level(level_b),
    .overflow(overflow_b), .frozen(frozen_b), .cnt_cycles(cyc_b),
    .cnt_branches(br_b), .cnt_taken(tk_b), .cnt_disc(disc_b)
  );

  always #5 clock = ~clock;

  function automatic ent_t mk(input logic [31:0] p, input logic [31:0] t,
                              input logic [2:0] f, input logic tk, input logic br);
    ent_t e;
    e.pc = p; e.target = t; e.funct3 = f; e.taken = tk; e.is_branch = br;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [31:0] p, input logic [31:0] ins,
                     input logic tk, input logic [31:0] tgt, input logic rdy);
    enable = en; pc = p; id_instr = ins; branch_taken = tk;
    branch_target = tgt; rd_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every accepted pop of the main instance is checked against the queue
  always @(negedge clock) begin
    if (reset && rd_a.rd_valid && rd_a.rd_ready) begin
      mon_act = '{rd_a.rd_pc, rd_a.rd_target, rd_a.rd_funct3, rd_a.rd_taken, rd_a.rd_is_branch};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got %0h, expected no entry", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL pop_entry: got %0h, expected %0h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", 64'(rd_a.rd_valid), 64'd0);
    chk("reset_level", 64'(level_a), 64'd0);
    chk("reset_frozen", 64'(frozen_a), 64'd0);
    chk("reset_pc", 64'(rd_a.rd_pc), 64'd0);
    reset = 1'b1;

    cyc(1, 0, NOP, 0, 0, 0);
    cyc(1, 4, NOP, 0, 0, 0);
    cyc(1, 8, NOP, 0, 0, 0);
    cyc(1, 12, NOP, 0, 0, 0);
    chk("seq_cycles", 64'(cyc_a), 64'd4);
    chk("seq_valid", 64'(rd_a.rd_valid), 64'd0);

    exp_q.push_back(mk(12, 40, 3'd0, 0, 0));
    cyc(1, 40, NOP, 0, 0, 0);
    chk("jump_valid", 64'(rd_a.rd_valid), 64'd1);
    chk("jump_level", 64'(level_a), 64'd1);
    chk("jump_disc", 64'(disc_a), 64'd1);

    exp_q.push_back(mk(44, 100, 3'b101, 1, 1));
    cyc(1, 44, BGE, 1, 100, 0);
    chk("bge_branches", 64'(br_a), 64'd1);
    chk("bge_taken", 64'(tk_a), 64'd1);
    chk("bge_disc", 64'(disc_a), 64'd1);

    exp_q.push_back(mk(44, 100, 3'd0, 0, 0));
    cyc(1, 100, NOP, 0, 0, 0);
    chk("redir_level", 64'(level_a), 64'd3);

    repeat (3) cyc(0, 100, NOP, 0, 0, 1);
    chk("drain_level", 64'(level_a), 64'd0);
    cyc(0, 100, NOP, 0, 0, 1);
    chk("empty_pop_level", 64'(level_a), 64'd0);

    cyc(0, 500, NOP, 0, 0, 0);
    chk("idle_cycles", 64'(cyc_a), 64'd7);
    cyc(1, 100, NOP, 0, 0, 0);
    chk("stall_level", 64'(level_a), 64'd0);
    chk("stall_disc", 64'(disc_a), 64'd2);

    exp_q.push_back(mk(104, 200, 3'd0, 0, 1));
    cyc(1, 104, BEQ, 0, 200, 0);
    chk("beq_branches", 64'(br_a), 64'd2);
    chk("beq_taken", 64'(tk_a), 64'd1);
    cyc(0, 104, NOP, 0, 0, 1);

    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk((i == 0) ? 32'd104 : 32'(100 + 100 * i), 32'(200 + 100 * i), 3'd0, 0, 0));
      cyc(1, 32'(200 + 100 * i), NOP, 0, 0, 0);
    end
    chk("fill_level", 64'(level_a), 64'd4);
    chk("fill_overflow", 64'(overflow_a), 64'd0);

    exp_q.push_back(mk(500, 600, 3'd0, 0, 0));
    cyc(1, 600, NOP, 0, 0, 1);
    chk("fullpop_level", 64'(level_a), 64'd4);
    chk("fullpop_overflow", 64'(overflow_a), 64'd0);
    chk("fullpop_level_nov", 64'(level_b), 64'd4);
    chk("fullpop_overflow_nov", 64'(overflow_b), 64'd0);

    exp_q.push_back(mk(600, 700, 3'd0, 0, 0));
    cyc(1, 700, NOP, 0, 0, 0);
    void'(exp_q.pop_front());
    chk("ovf_level", 64'(level_a), 64'd4);
    chk("ovf_flag", 64'(overflow_a), 64'd1);
    chk("ovf_head_pc", 64'(rd_a.rd_pc), 64'd300);
    chk("ovf_head_target", 64'(rd_a.rd_target), 64'd400);
    chk("ovf_flag_nov", 64'(overflow_b), 64'd1);
    chk("ovf_head_pc_nov", 64'(rd_b.rd_pc), 64'd200);
    chk("ovf_cycles", 64'(cyc_a), 64'd15);
    chk("ovf_disc", 64'(disc_a), 64'd8);
    cyc(0, 700, NOP, 0, 0, 1);

    clear = 1'b1;
    cyc(1, 900, BGE, 1, 4, 0);
    clear = 1'b0;
    exp_q.delete();
    chk("clear_level", 64'(level_a), 64'd0);
    chk("clear_overflow", 64'(overflow_a), 64'd0);
    chk("clear_cycles", 64'(cyc_a), 64'd0);
    chk("clear_branches", 64'(br_a), 64'd0);
    chk("clear_level_nov", 64'(level_b), 64'd0);

    trig_en = 1'b1;
    trig_pc = 32'd40;
    cyc(1, 32, NOP, 0, 0, 0);
    chk("first_level", 64'(level_a), 64'd0);
    exp_q.push_back(mk(32, 40, 3'd0, 0, 0));
    cyc(1, 40, NOP, 0, 0, 0);
    chk("trig_frozen", 64'(frozen_a), 64'd0);
    exp_q.push_back(mk(40, 80, 3'd0, 0, 0));
    cyc(1, 80, NOP, 0, 0, 0);
    chk("post1_frozen", 64'(frozen_a), 64'd0);
    exp_q.push_back(mk(80, 120, 3'd0, 0, 0));
    cyc(1, 120, NOP, 0, 0, 0);
    chk("post2_frozen", 64'(frozen_a), 64'd1);
    chk("post2_level", 64'(level_a), 64'd3);
    cyc(1, 40, NOP, 0, 0, 0);
    cyc(1, 44, BGE, 1, 100, 0);
    chk("frz_level", 64'(level_a), 64'd3);
    chk("frz_disc", 64'(disc_a), 64'd4);
    chk("frz_branches", 64'(br_a), 64'd1);
    repeat (3) cyc(0, 44, NOP, 0, 0, 1);
    chk("frz_drain_level", 64'(level_a), 64'd0);
    chk("frz_still", 64'(frozen_a), 64'd1);
    clear = 1'b1;
    cyc(0, 44, NOP, 0, 0, 0);
    clear = 1'b0;
    trig_en = 1'b0;
    chk("unfreeze", 64'(frozen_a), 64'd0);

    cyc(1, 0, NOP, 0, 0, 0);
    cyc(1, 64, NOP, 0, 0, 0);
    chk("pre_reset_valid", 64'(rd_a.rd_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valid", 64'(rd_a.rd_valid), 64'd0);
    chk("async_reset_level", 64'(level_a), 64'd0);
    chk("async_reset_cycles", 64'(cyc_a), 64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc(0, 64, NOP, 0, 0, 0);
    chk("post_reset_pc", 64'(rd_a.rd_pc), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
